// File: rtl/dna_window_feeder_if.sv
// Base-stream and comparator-side signals of the DNA window feeder.
// The master modport is the feeder; the slave modport is its environment.
interface dna_window_feeder_if #(
    parameter int BASES = 32,
    parameter int LEN_W = 16
);
    logic [1:0]         base_in;
    logic               base_valid;
    logic               base_ready;
    logic [2*BASES-1:0] data;
    logic               window_valid;
    logic [LEN_W-1:0]   window_pos;
    logic               match;

    modport master (
        input  base_in, base_valid, match,
        output base_ready, data, window_valid, window_pos
    );

    modport slave (
        output base_in, base_valid, match,
        input  base_ready, data, window_valid, window_pos
    );
endinterface

// File: rtl/dna_window_feeder.sv
// Assembles a sliding 32-base window from a 2-bit base stream for the comparator,
// aligns the comparator's match result with each window and reports hits.
module dna_window_feeder #(
    parameter int BASES         = 32,
    parameter int LEN_W         = 16,
    parameter int MATCH_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] seq_len,
    dna_window_feeder_if.master bus,
    output logic             hit,
    output logic [LEN_W-1:0] hit_pos,
    output logic [LEN_W-1:0] hit_count,
    output logic             busy,
    output logic             done
);
    localparam logic [LEN_W-1:0] BASES_L    = LEN_W'(BASES);
    localparam logic [2:0]       DRAIN_LAST = 3'(MATCH_LATENCY);

    typedef enum logic [2:0] {IDLE, FILL, SLIDE, DRAIN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] acc;
    logic [2:0]       drain_cnt;

    logic             accept;
    logic [LEN_W-1:0] acc_next;
    logic             clear_hits;

    assign accept     = bus.base_valid && bus.base_ready;
    assign acc_next   = acc + LEN_W'(1);
    assign clear_hits = (state == IDLE) && start;

    // NOTE: all state here uses <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            len              <= '0;
            acc              <= '0;
            drain_cnt        <= '0;
            bus.base_ready   <= 1'b0;
            bus.data         <= '0;
            bus.window_valid <= 1'b0;
            bus.window_pos   <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            bus.window_valid <= 1'b0;
            done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len      <= seq_len;
                        acc      <= '0;
                        bus.data <= '0;
                        busy     <= 1'b1;
                        if (seq_len == '0) begin
                            state <= DONE;
                        end else begin
                            state          <= FILL;
                            bus.base_ready <= 1'b1;
                        end
                    end
                end
                FILL, SLIDE: begin
                    if (accept) begin
                        bus.data <= {bus.data[2*BASES-3:0], bus.base_in};
                        acc      <= acc_next;
                        if (acc_next >= BASES_L) begin
                            bus.window_valid <= 1'b1;
                            bus.window_pos   <= acc_next - BASES_L;
                        end
                        // Sequence end wins over window fill when seq_len == BASES.
                        if (acc_next == len) begin
                            state          <= DRAIN;
                            bus.base_ready <= 1'b0;
                            drain_cnt      <= '0;
                        end else if (acc_next == BASES_L) begin
                            state <= SLIDE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [MATCH_LATENCY-1:0] dly_valid;
    logic [LEN_W-1:0]         dly_pos [MATCH_LATENCY];

    // NOTE: the delay pipeline is reset so a reset mid-run can never leak a stale hit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dly_valid <= '0;
            for (int i = 0; i < MATCH_LATENCY; i++) dly_pos[i] <= '0;
            hit       <= 1'b0;
            hit_pos   <= '0;
            hit_count <= '0;
        end else begin
            dly_valid[0] <= bus.window_valid;
            dly_pos[0]   <= bus.window_pos;
            for (int i = 1; i < MATCH_LATENCY; i++) begin
                dly_valid[i] <= dly_valid[i-1];
                dly_pos[i]   <= dly_pos[i-1];
            end
            hit <= dly_valid[MATCH_LATENCY-1] && bus.match;
            if (dly_valid[MATCH_LATENCY-1] && bus.match) begin
                hit_pos <= dly_pos[MATCH_LATENCY-1];
                if (hit_count != '1) hit_count <= hit_count + LEN_W'(1);
            end
            if (clear_hits) hit_count <= '0;
        end
    end
endmodule

// File: tb/tb_dna_window_feeder.sv
// Self-checking bench for dna_window_feeder with a behavioural comparator and
// a window/hit reference model computed directly from the base sequence.
module tb_dna_window_feeder;
    localparam int BASES = 32;
    localparam int LEN_W = 16;
    localparam int LAT   = 1;
    localparam logic [63:0] T1 = 64'h20C7A176AAFA69E7;
    localparam logic [63:0] T2 = 64'h20C6A176AAFA69E7;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             start   = 1'b0;
    logic [LEN_W-1:0] seq_len = '0;
    logic             hit;
    logic [LEN_W-1:0] hit_pos;
    logic [LEN_W-1:0] hit_count;
    logic             busy;
    logic             done;

    dna_window_feeder_if #(.BASES(BASES), .LEN_W(LEN_W)) bus ();

    dna_window_feeder #(.BASES(BASES), .LEN_W(LEN_W), .MATCH_LATENCY(LAT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .seq_len   (seq_len),
        .bus       (bus),
        .hit       (hit),
        .hit_pos   (hit_pos),
        .hit_count (hit_count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Comparator stand-in: registered equality against a template, LAT cycles deep.
    logic [63:0] cmp_tmpl = T1;
    logic [3:0]  mpipe;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) mpipe <= '0;
        else          mpipe <= {mpipe[2:0], bus.data == cmp_tmpl};
    end
    assign bus.match = mpipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int          wpos_q[$];
    logic [63:0] wdat_q[$];
    int          hpos_q[$];
    int          done_cnt, hits_at_done, acc_cnt, ready_seen, data_bad;
    logic [63:0] prev_data = '0;
    bit          prev_upd  = 1'b1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.window_valid) begin
                wpos_q.push_back(int'(bus.window_pos));
                wdat_q.push_back(bus.data);
            end
            if (hit) hpos_q.push_back(int'(hit_pos));
            if (done) begin
                done_cnt++;
                hits_at_done = hpos_q.size();
            end
            if (bus.base_ready) ready_seen++;
            if (!prev_upd && bus.data !== prev_data) data_bad++;
            prev_upd = (bus.base_valid && bus.base_ready) || (start && !busy);
            if (bus.base_valid && bus.base_ready) acc_cnt++;
        end else begin
            prev_upd = 1'b1;
        end
        prev_data = bus.data;
    end

    logic [1:0] seq [0:127];

    task automatic fill(input int len, input logic [63:0] t, input int tpos, input bit rnd);
        for (int i = 0; i < len; i++) seq[i] = rnd ? 2'($urandom) : 2'b00;
        if (tpos >= 0)
            for (int k = 0; k < BASES; k++) seq[tpos+k] = t[63-2*k -: 2];
    endtask

    function automatic logic [63:0] win_at(input int p);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < BASES; k++) w[63-2*k -: 2] = seq[p+k];
        return w;
    endfunction

    task automatic clear_mon();
        wpos_q.delete();
        wdat_q.delete();
        hpos_q.delete();
        done_cnt = 0; hits_at_done = 0; acc_cnt = 0; ready_seen = 0;
    endtask

    task automatic start_seq(input int len);
        start   = 1'b1;
        seq_len = LEN_W'(len);
        @(posedge clock); #1;
        start   = 1'b0;
    endtask

    task automatic feed(input int len, input bit gaps, input int stop_after, input int start_at);
        int idx = 0;
        int cyc = 0;
        bit pulsed = 1'b0;
        bit v, rdy;
        while (idx < len && idx != stop_after && cyc < 2000) begin
            v = gaps ? (cyc % 2 == 0 && $urandom_range(0, 3) != 0) : 1'b1;
            bus.base_in    = seq[idx];
            bus.base_valid = v;
            start = (start_at >= 0 && idx == start_at && !pulsed);
            if (start) begin
                pulsed  = 1'b1;
                seq_len = LEN_W'(5);
            end
            rdy = bus.base_ready;
            @(posedge clock); #1;
            if (v && rdy) idx++;
            cyc++;
        end
        bus.base_valid = 1'b0;
        start          = 1'b0;
        check("feed_accepted", 64'(idx), 64'(stop_after >= 0 ? stop_after : len));
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (3) @(posedge clock);
        #1;
        check("done_once", 64'(done_cnt), 64'(1));
    endtask

    task automatic verify(input string name, input int len);
        int exp_h[$];
        int nwin;
        nwin = (len >= BASES) ? len - BASES + 1 : 0;
        for (int p = 0; p < nwin; p++)
            if (win_at(p) == cmp_tmpl) exp_h.push_back(p);
        check({name, ":n_windows"}, 64'(wpos_q.size()), 64'(nwin));
        for (int i = 0; i < wpos_q.size() && i < nwin; i++) begin
            check({name, ":window_pos"}, 64'(wpos_q[i]), 64'(i));
            check({name, ":window_data"}, wdat_q[i], win_at(i));
        end
        check({name, ":n_hits"}, 64'(hpos_q.size()), 64'(exp_h.size()));
        for (int i = 0; i < hpos_q.size() && i < exp_h.size(); i++)
            check({name, ":hit_pos"}, 64'(hpos_q[i]), 64'(exp_h[i]));
        check({name, ":hit_count"}, 64'(hit_count), 64'(exp_h.size()));
        check({name, ":hits_before_done"}, 64'(hits_at_done), 64'(exp_h.size()));
        check({name, ":accepted"}, 64'(acc_cnt), 64'(len));
        check({name, ":data_stable"}, 64'(data_bad), 64'(0));
    endtask

    task automatic run(input string name, input int len, input bit gaps,
                       input int start_at, input bit check_first);
        clear_mon();
        start_seq(len);
        if (check_first) begin
            check({name, ":busy_after_start"}, 64'(busy), 64'(1));
            check({name, ":ready_after_start"}, 64'(bus.base_ready), 64'(1));
        end
        feed(len, gaps, -1, start_at);
        wait_done();
        verify(name, len);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ":data"}, bus.data, 64'(0));
        check({name, ":window_valid"}, 64'(bus.window_valid), 64'(0));
        check({name, ":window_pos"}, 64'(bus.window_pos), 64'(0));
        check({name, ":base_ready"}, 64'(bus.base_ready), 64'(0));
        check({name, ":hit"}, 64'(hit), 64'(0));
        check({name, ":hit_pos"}, 64'(hit_pos), 64'(0));
        check({name, ":hit_count"}, 64'(hit_count), 64'(0));
        check({name, ":busy"}, 64'(busy), 64'(0));
        check({name, ":done"}, 64'(done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, tpos;
        bus.base_in    = 2'b00;
        bus.base_valid = 1'b0;
        clear_mon();
        data_bad = 0;

        // Reset held with random inputs toggling.
        for (int i = 0; i < 6; i++) begin
            start          = 1'($urandom);
            seq_len        = LEN_W'($urandom);
            bus.base_in    = 2'($urandom);
            bus.base_valid = 1'($urandom);
            @(posedge clock); #1;
        end
        check_outputs_zero("reset");
        start = 1'b0;
        bus.base_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Exact window of the template.
        cmp_tmpl = T1;
        fill(32, T1, 0, 1'b0);
        run("exact", 32, 1'b0, -1, 1'b1);

        // Sliding search, then with a one-bit template change.
        fill(40, T1, 5, 1'b0);
        run("slide", 40, 1'b0, -1, 1'b0);
        cmp_tmpl = T2;
        run("slide_nomatch", 40, 1'b0, -1, 1'b0);
        cmp_tmpl = T1;

        // Handshake gaps with random stalls.
        run("gaps", 40, 1'b1, -1, 1'b0);

        // Start pulsed mid-SLIDE is ignored.
        run("start_mid", 40, 1'b0, 35, 1'b0);

        // Short sequence.
        fill(10, T1, -1, 1'b1);
        run("short", 10, 1'b0, -1, 1'b0);

        // Zero-length sequence.
        clear_mon();
        start_seq(0);
        check("len0:done_c1", 64'(done), 64'(0));
        @(posedge clock); #1;
        check("len0:done_c2", 64'(done), 64'(1));
        @(posedge clock); #1;
        check("len0:done_c3", 64'(done), 64'(0));
        check("len0:busy", 64'(busy), 64'(0));
        check("len0:ready_never", 64'(ready_seen), 64'(0));

        // Reset mid-SLIDE after 35 of 40 bases, with one hit already counted.
        fill(40, T1, 0, 1'b0);
        clear_mon();
        start_seq(40);
        feed(40, 1'b0, 35, -1);
        check("abort:hit_count_before", 64'(hit_count), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("abort:no_done", 64'(done_cnt), 64'(0));
        fill(32, T1, 0, 1'b0);
        run("after_abort", 32, 1'b0, -1, 1'b1);

        // Randomized sequences with a template planted at a random position.
        for (int r = 0; r < 4; r++) begin
            len  = $urandom_range(32, 70);
            tpos = $urandom_range(0, len - BASES);
            fill(len, T1, tpos, 1'b1);
            run("random", len, 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
